// File: rtl/fp_pkg.sv
// Shared floating-point result definitions.
//   fp_flags_t    : exception flags {NV,DZ,OF,UF,NX} = [4:0]
//   FLG_*         : bit positions inside fp_flags_t
//   NANBOX_HI     : upper word written over single-precision results
//   fpres_entry_t : one committed-result record (default tag width)
package fp_pkg;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  typedef logic [4:0] fp_flags_t;

  localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

  localparam int TAGW_DEF = 5;

  typedef struct packed {
    logic [63:0]         result;
    fp_flags_t           flags;
    logic                denorm;
    logic [TAGW_DEF-1:0] tag;
  } fpres_entry_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO holding result records.
//   clk, reset : clock, synchronous active-high reset (drops all entries)
//   push, pop  : write tail / retire head (caller guarantees legality)
//   wdata      : record written on push
//   head       : record at head (stale when empty)
//   count      : occupancy 0..DEPTH
module fp_sync_fifo
  import fp_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fpres_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wdata,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fpadd_result_stage.sv
// Commit stage behind the combinational fpadd.
//   in_*          : fpadd result, flags, denorm, precision and destination tag
//   out_*         : head record towards writeback (zeros when empty)
//   fflags*       : sticky architectural flags with CSR write / clear
//   denorm_cnt    : saturating count of committed denormal results
//   count         : FIFO occupancy
// Flags and the denormal counter only move on pop: a queued op is not
// architectural until writeback takes it.
module fpadd_result_stage
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 5,
  parameter int DCNTW = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_result,
  input  fp_flags_t              in_flags,
  input  logic                   in_denorm,
  input  logic                   in_p,
  input  logic [TAGW-1:0]        in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_result,
  output fp_flags_t              out_flags,
  output logic [TAGW-1:0]        out_tag,
  output fp_flags_t              fflags,
  input  logic                   fflags_we,
  input  fp_flags_t              fflags_wdata,
  input  logic                   fflags_clr,
  output logic [DCNTW-1:0]       denorm_cnt,
  output logic [$clog2(DEPTH):0] count
);

  // Same layout as fpres_entry_t, but with the tag sized by TAGW.
  typedef struct packed {
    logic [63:0]     result;
    fp_flags_t       flags;
    logic            denorm;
    logic [TAGW-1:0] tag;
  } entry_t;

  localparam logic [$clog2(DEPTH):0] FULL_CNT = ($clog2(DEPTH)+1)'(DEPTH);

  entry_t    wr_entry;
  entry_t    head;
  logic      push;
  logic      pop;
  fp_flags_t pop_flags;
  logic      pop_denorm;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Single-precision results are NaN-boxed into the 64-bit register file.
  assign wr_entry.result = in_p ? {NANBOX_HI, in_result[31:0]} : in_result;
  assign wr_entry.flags  = in_flags;
  assign wr_entry.denorm = in_denorm;
  assign wr_entry.tag    = in_tag;

  fp_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .head  (head),
    .count (count)
  );

  assign out_result = out_valid ? head.result : '0;
  assign out_flags  = out_valid ? head.flags  : '0;
  assign out_tag    = out_valid ? head.tag    : '0;

  assign pop_flags  = pop ? head.flags : '0;
  assign pop_denorm = pop & head.denorm;

  // A CSR write or clear in the same cycle as a commit still keeps the
  // committed op's flags, so no exception is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      fflags <= '0;
    end else if (fflags_we) begin
      fflags <= fflags_wdata | pop_flags;
    end else if (fflags_clr) begin
      fflags <= pop_flags;
    end else begin
      fflags <= fflags | pop_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      denorm_cnt <= '0;
    end else if (fflags_clr) begin
      denorm_cnt <= DCNTW'(pop_denorm);
    end else if (pop_denorm && (denorm_cnt != '1)) begin
      denorm_cnt <= denorm_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fpadd_result_stage.sv
module tb_fpadd_result_stage;
  import fp_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAGW  = 5;
  localparam int DCNTW = 2;
  localparam int DMAX  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [63:0]     in_result = '0;
  logic [4:0]      in_flags = '0;
  logic            in_denorm = 1'b0;
  logic            in_p = 1'b0;
  logic [TAGW-1:0] in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [63:0]     out_result;
  logic [4:0]      out_flags;
  logic [TAGW-1:0] out_tag;
  logic [4:0]      fflags;
  logic            fflags_we = 1'b0;
  logic [4:0]      fflags_wdata = '0;
  logic            fflags_clr = 1'b0;
  logic [DCNTW-1:0] denorm_cnt;
  logic [2:0]      count;

  always #5 clk = ~clk;

  fpadd_result_stage #(.DEPTH(DEPTH), .TAGW(TAGW), .DCNTW(DCNTW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_denorm(in_denorm), .in_p(in_p), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_tag(out_tag),
    .fflags(fflags), .fflags_we(fflags_we), .fflags_wdata(fflags_wdata),
    .fflags_clr(fflags_clr), .denorm_cnt(denorm_cnt), .count(count)
  );

  typedef struct {
    logic [63:0]     res;
    logic [4:0]      fl;
    logic            dn;
    logic [TAGW-1:0] tag;
  } mentry_t;

  mentry_t    mq[$];
  logic [4:0] m_fflags = '0;
  int         m_dcnt = 0;
  int         checks = 0;
  int         failures = 0;

  // Reference model: advance by one clock using the currently driven inputs,
  // then let the DUT take the same edge and settle.
  task automatic cycle();
    bit         m_push, m_pop, h_dn;
    logic [4:0] h_fl;
    mentry_t    e;
    m_pop  = (mq.size() != 0) && out_ready;
    m_push = in_valid && (mq.size() < DEPTH);
    if (reset) begin
      mq.delete();
      m_fflags = '0;
      m_dcnt   = 0;
    end else begin
      h_fl = m_pop ? mq[0].fl : 5'b0;
      h_dn = m_pop && mq[0].dn;
      if (fflags_we)       m_fflags = fflags_wdata | h_fl;
      else if (fflags_clr) m_fflags = h_fl;
      else                 m_fflags = m_fflags | h_fl;
      if (fflags_clr)              m_dcnt = h_dn ? 1 : 0;
      else if (h_dn && m_dcnt < DMAX) m_dcnt = m_dcnt + 1;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        e.res = in_p ? {32'hFFFF_FFFF, in_result[31:0]} : in_result;
        e.fl  = in_flags;
        e.dn  = in_denorm;
        e.tag = in_tag;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; fflags_we = 0; fflags_clr = 0;
    in_p = 0; in_denorm = 0; in_flags = '0; in_result = '0; in_tag = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; cycle(); cycle();
    reset = 0; cycle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (fflags !== 5'b0) begin failures++; $display("FAIL reset_fflags got=%b exp=00000", fflags); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_result !== 64'h0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
    checks++; if (denorm_cnt !== 2'd0) begin failures++; $display("FAIL reset_denorm_cnt got=%0d exp=0", denorm_cnt); end
  endtask

  task automatic test_fill_drain();
    idle_inputs();
    in_result = 64'h3FF0_0000_0000_0000; in_flags = 5'b00001;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_tag = TAGW'(i); cycle();
    end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
    checks++; if (fflags !== 5'b0) begin failures++; $display("FAIL fill_no_accum got=%b exp=00000", fflags); end
    in_tag = 5; cycle();
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fifth_push_count got=%0d exp=4", count); end
    in_valid = 0; out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_tag !== TAGW'(i)) begin failures++; $display("FAIL drain_tag got=%0d exp=%0d", out_tag, i); end
      checks++; if (out_result !== 64'h3FF0_0000_0000_0000) begin failures++; $display("FAIL drain_result got=%h exp=3ff0000000000000", out_result); end
      cycle();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drained_out_valid got=%0b exp=0", out_valid); end
    checks++; if (fflags !== 5'b00001) begin failures++; $display("FAIL drained_fflags got=%b exp=00001", fflags); end
    out_ready = 0;
  endtask

  task automatic test_nanbox();
    idle_inputs();
    in_valid = 1; in_p = 1; in_result = 64'h0000_0000_3F80_0000; in_tag = 7; cycle();
    in_valid = 0; in_p = 0;
    checks++; if (out_result !== 64'hFFFF_FFFF_3F80_0000) begin failures++; $display("FAIL nanbox got=%h exp=ffffffff3f800000", out_result); end
    checks++; if (out_tag !== 5'd7) begin failures++; $display("FAIL nanbox_tag got=%0d exp=7", out_tag); end
    out_ready = 1; cycle(); out_ready = 0;
  endtask

  task automatic test_flag_accum();
    idle_inputs();
    fflags_clr = 1; cycle(); fflags_clr = 0;
    in_valid = 1; in_flags = 5'b00100; cycle();
    in_flags = 5'b00011; cycle();
    in_valid = 0;
    checks++; if (fflags !== 5'b0) begin failures++; $display("FAIL push_only_fflags got=%b exp=00000", fflags); end
    out_ready = 1; cycle();
    checks++; if (fflags !== 5'b00100) begin failures++; $display("FAIL commit1_fflags got=%b exp=00100", fflags); end
    cycle(); out_ready = 0;
    checks++; if (fflags !== 5'b00111) begin failures++; $display("FAIL commit2_fflags got=%b exp=00111", fflags); end
  endtask

  task automatic test_same_cycle_csr();
    idle_inputs();
    fflags_clr = 1; cycle(); fflags_clr = 0;
    in_valid = 1; in_flags = 5'b00001; cycle(); in_valid = 0;
    out_ready = 1; fflags_we = 1; fflags_wdata = 5'b10000; cycle();
    out_ready = 0; fflags_we = 0;
    checks++; if (fflags !== 5'b10001) begin failures++; $display("FAIL we_with_pop got=%b exp=10001", fflags); end
    in_valid = 1; in_flags = 5'b00100; cycle(); in_valid = 0;
    out_ready = 1; fflags_clr = 1; cycle();
    out_ready = 0; fflags_clr = 0;
    checks++; if (fflags !== 5'b00100) begin failures++; $display("FAIL clr_with_pop got=%b exp=00100", fflags); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    in_valid = 1; in_tag = 1; cycle();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_tag = TAGW'(i + 2); cycle();
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL stream_count got=%0d exp=1", count); end
      checks++; if (out_tag !== TAGW'(i + 2)) begin failures++; $display("FAIL stream_tag got=%0d exp=%0d", out_tag, i + 2); end
    end
    reset = 1; cycle(); reset = 0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%0b exp=0", out_valid); end
    idle_inputs(); cycle();
  endtask

  task automatic test_denorm_sat();
    int exp_cnt[5] = '{1, 2, 3, 3, 3};
    idle_inputs();
    fflags_clr = 1; cycle(); fflags_clr = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1; in_denorm = 1; out_ready = 0; cycle();
      in_valid = 0; in_denorm = 0; out_ready = 1; cycle();
      checks++; if (denorm_cnt !== DCNTW'(exp_cnt[k])) begin failures++; $display("FAIL denorm_sat got=%0d exp=%0d", denorm_cnt, exp_cnt[k]); end
    end
    out_ready = 0;
    in_valid = 1; in_denorm = 1; cycle(); in_valid = 0; in_denorm = 0;
    fflags_we = 1; fflags_wdata = 5'b11111; cycle(); fflags_we = 0;
    checks++; if (denorm_cnt !== 2'd3) begin failures++; $display("FAIL denorm_we_hold got=%0d exp=3", denorm_cnt); end
    out_ready = 1; fflags_clr = 1; cycle();
    out_ready = 0; fflags_clr = 0;
    checks++; if (denorm_cnt !== 2'd1) begin failures++; $display("FAIL denorm_clr_pop got=%0d exp=1", denorm_cnt); end
  endtask

  task automatic test_random();
    logic [63:0] e_res;
    logic [4:0]  e_fl;
    logic [TAGW-1:0] e_tag;
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      in_valid     = ($urandom_range(0, 99) < 60);
      out_ready    = ($urandom_range(0, 99) < 50);
      in_result    = {$urandom, $urandom};
      in_flags     = 5'($urandom);
      in_denorm    = ($urandom_range(0, 99) < 30);
      in_p         = $urandom_range(0, 1) == 1;
      in_tag       = TAGW'($urandom);
      fflags_we    = ($urandom_range(0, 99) < 5);
      fflags_wdata = 5'($urandom);
      fflags_clr   = ($urandom_range(0, 99) < 5);
      reset        = ($urandom_range(0, 199) == 0);
      cycle();
      e_res = (mq.size() != 0) ? mq[0].res : 64'h0;
      e_fl  = (mq.size() != 0) ? mq[0].fl : 5'h0;
      e_tag = (mq.size() != 0) ? mq[0].tag : '0;
      checks++; if (count !== 3'(mq.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, mq.size()); end
      checks++; if (out_valid !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%0b", i, out_valid); end
      checks++; if (in_ready !== (mq.size() != DEPTH)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0b", i, in_ready); end
      checks++; if (out_result !== e_res) begin failures++; $display("FAIL rnd_out_result cyc=%0d got=%h exp=%h", i, out_result, e_res); end
      checks++; if (out_flags !== e_fl) begin failures++; $display("FAIL rnd_out_flags cyc=%0d got=%b exp=%b", i, out_flags, e_fl); end
      checks++; if (out_tag !== e_tag) begin failures++; $display("FAIL rnd_out_tag cyc=%0d got=%0d exp=%0d", i, out_tag, e_tag); end
      checks++; if (fflags !== m_fflags) begin failures++; $display("FAIL rnd_fflags cyc=%0d got=%b exp=%b", i, fflags, m_fflags); end
      checks++; if (denorm_cnt !== DCNTW'(m_dcnt)) begin failures++; $display("FAIL rnd_denorm_cnt cyc=%0d got=%0d exp=%0d", i, denorm_cnt, m_dcnt); end
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_nanbox();
    test_flag_accum();
    test_same_cycle_csr();
    test_back_to_back();
    test_denorm_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
